// File: rtl/pf_stream_engine.sv
// Stream prefetch engine: buffers prefetch descriptors and expands each into
// line requests interleaved by address across NCH cache-pipe channels.
module pf_stream_engine #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned ADDR_W   = 44,
  parameter int unsigned STRIDE_W = 8,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned STAT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_retry,
  input  logic [ADDR_W-1:0]     op_addr,
  input  logic [STRIDE_W-1:0]   op_stride,
  input  logic [CNT_W-1:0]      op_count,
  input  logic                  op_l2,
  output logic [NCH-1:0]        req_valid,
  input  logic [NCH-1:0]        req_retry,
  output logic [NCH*ADDR_W-1:0] req_addr,
  output logic [NCH-1:0]        req_l2,
  output logic [STAT_W-1:0]     stat_issued,
  output logic [STAT_W-1:0]     stat_stall,
  output logic [STAT_W-1:0]     stat_drop
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PC_W  = CH_W + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  // Descriptor FIFO storage and pointers
  logic [ADDR_W-1:0]   fifo_addr   [DEPTH];
  logic [STRIDE_W-1:0] fifo_stride [DEPTH];
  logic [CNT_W-1:0]    fifo_count  [DEPTH];
  logic                fifo_l2     [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;

  logic full_c, empty_c, push_c, pop_c;
  logic load_c, drop_c, wr_c, stall_c, writable_c;

  state_t state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [STRIDE_W-1:0] cur_stride_q;
  logic [CNT_W-1:0]    remain_q;
  logic                cur_l2_q;
  logic [CH_W-1:0]     ch_c;
  logic [ADDR_W-1:0]   stride_ext_c;
  logic [PC_W-1:0]     issued_cnt_c;

  assign full_c   = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                    (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign empty_c  = (wr_ptr == rd_ptr);
  assign op_retry = full_c;
  assign push_c   = op_valid && !full_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Payload storage needs no reset; only pointers define occupancy
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_addr[wr_ptr[IDX_W-1:0]]   <= op_addr;
      fifo_stride[wr_ptr[IDX_W-1:0]] <= op_stride;
      fifo_count[wr_ptr[IDX_W-1:0]]  <= op_count;
      fifo_l2[wr_ptr[IDX_W-1:0]]     <= op_l2;
    end
  end

  // Target channel is the low address bits of the current line
  generate
    if (NCH > 1) begin : g_ch
      assign ch_c = cur_addr_q[CH_W-1:0];
    end else begin : g_ch1
      assign ch_c = '0;
    end
  endgenerate

  assign writable_c   = !req_valid[ch_c] || !req_retry[ch_c];
  assign stride_ext_c = {{(ADDR_W-STRIDE_W){cur_stride_q[STRIDE_W-1]}}, cur_stride_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    load_c  = 1'b0;
    drop_c  = 1'b0;
    wr_c    = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_c) begin
          pop_c = 1'b1;
          if (fifo_count[rd_ptr[IDX_W-1:0]] == '0) begin
            drop_c = 1'b1;
          end else begin
            load_c  = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (writable_c) begin
          wr_c = 1'b1;
          if (remain_q == CNT_W'(1)) state_d = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Generator walk state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr_q   <= '0;
      cur_stride_q <= '0;
      remain_q     <= '0;
      cur_l2_q     <= 1'b0;
    end else if (load_c) begin
      cur_addr_q   <= fifo_addr[rd_ptr[IDX_W-1:0]];
      cur_stride_q <= fifo_stride[rd_ptr[IDX_W-1:0]];
      remain_q     <= fifo_count[rd_ptr[IDX_W-1:0]];
      cur_l2_q     <= fifo_l2[rd_ptr[IDX_W-1:0]];
    end else if (wr_c) begin
      cur_addr_q <= cur_addr_q + stride_ext_c;
      remain_q   <= remain_q - CNT_W'(1);
    end
  end

  // Per-channel request slots; a write on a draining slot replaces it bubble-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_valid <= '0;
      req_addr  <= '0;
      req_l2    <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (wr_c && (ch_c == CH_W'(c))) begin
          req_valid[c]                 <= 1'b1;
          req_addr[c*ADDR_W +: ADDR_W] <= cur_addr_q;
          req_l2[c]                    <= cur_l2_q;
        end else if (!req_retry[c]) begin
          req_valid[c] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    issued_cnt_c = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      issued_cnt_c = issued_cnt_c + PC_W'(req_valid[c] && !req_retry[c]);
    end
  end

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] v,
                                                input logic [PC_W-1:0]   inc);
    logic [STAT_W:0] s;
    s = {1'b0, v} + (STAT_W+1)'(inc);
    return s[STAT_W] ? '1 : s[STAT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_issued <= '0;
      stat_stall  <= '0;
      stat_drop   <= '0;
    end else begin
      stat_issued <= sat_add(stat_issued, issued_cnt_c);
      stat_stall  <= sat_add(stat_stall, PC_W'(stall_c));
      stat_drop   <= sat_add(stat_drop, PC_W'(drop_c));
    end
  end

endmodule

// File: tb/tb_pf_stream_engine.sv
// Directed bench for pf_stream_engine with a per-channel request scoreboard.
module tb_pf_stream_engine;

  localparam int unsigned NCH      = 2;
  localparam int unsigned ADDR_W   = 44;
  localparam int unsigned STRIDE_W = 8;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned STAT_W   = 16;

  logic                  clk;
  logic                  reset;
  logic                  op_valid;
  logic                  op_retry;
  logic [ADDR_W-1:0]     op_addr;
  logic [STRIDE_W-1:0]   op_stride;
  logic [CNT_W-1:0]      op_count;
  logic                  op_l2;
  logic [NCH-1:0]        req_valid;
  logic [NCH-1:0]        req_retry;
  logic [NCH*ADDR_W-1:0] req_addr;
  logic [NCH-1:0]        req_l2;
  logic [STAT_W-1:0]     stat_issued;
  logic [STAT_W-1:0]     stat_stall;
  logic [STAT_W-1:0]     stat_drop;

  int n_checks = 0;
  int n_fail   = 0;
  int n_exp_issued = 0;
  logic [ADDR_W:0] sbq0[$];
  logic [ADDR_W:0] sbq1[$];

  pf_stream_engine #(
    .NCH(NCH), .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W),
    .CNT_W(CNT_W), .DEPTH(DEPTH), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_retry(op_retry), .op_addr(op_addr),
    .op_stride(op_stride), .op_count(op_count), .op_l2(op_l2),
    .req_valid(req_valid), .req_retry(req_retry), .req_addr(req_addr),
    .req_l2(req_l2), .stat_issued(stat_issued), .stat_stall(stat_stall),
    .stat_drop(stat_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [ADDR_W-1:0] ch_addr(input int c);
    return req_addr[c*ADDR_W +: ADDR_W];
  endfunction

  // Drive one descriptor, queue its expected requests, return after the accept edge
  task automatic push(input logic [ADDR_W-1:0] addr, input logic [STRIDE_W-1:0] stride,
                      input logic [CNT_W-1:0] count, input logic l2);
    logic [ADDR_W-1:0] a;
    int waited;
    op_valid  = 1'b1;
    op_addr   = addr;
    op_stride = stride;
    op_count  = count;
    op_l2     = l2;
    a = addr;
    for (int i = 0; i < int'(count); i++) begin
      if (a[0]) sbq1.push_back({l2, a});
      else      sbq0.push_back({l2, a});
      a = a + {{(ADDR_W-STRIDE_W){stride[STRIDE_W-1]}}, stride};
    end
    n_exp_issued += int'(count);
    waited = 0;
    while (op_retry && waited < 100) begin
      step();
      waited++;
    end
    n_checks++;
    assert (!op_retry) else begin
      n_fail++;
      $error("FAIL push_accept: observed op_retry=%0b expected 0", op_retry);
    end
    step();
    op_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while ((sbq0.size() != 0 || sbq1.size() != 0 || req_valid != '0) && w < 300) begin
      step();
      w++;
    end
    n_checks++;
    assert (w < 300) else begin
      n_fail++;
      $error("FAIL %s_drain: observed pending=%0d expected 0", tag, sbq0.size() + sbq1.size());
    end
    step(2);
  endtask

  // Scoreboard: every transfer must match the head of its channel's queue
  always @(negedge clk) begin
    if (reset) begin
      for (int c = 0; c < int'(NCH); c++) begin
        if (req_valid[c] && !req_retry[c]) begin
          automatic logic [ADDR_W:0] got = {req_l2[c], req_addr[c*ADDR_W +: ADDR_W]};
          automatic int qs = (c == 0) ? sbq0.size() : sbq1.size();
          n_checks++;
          assert (qs != 0) else begin
            n_fail++;
            $error("FAIL ch%0d_unexpected: observed 0x%0h expected no request", c, got);
          end
          if (qs != 0) begin
            if (c == 0) check("ch0_req", 64'(got), 64'(sbq0.pop_front()));
            else        check("ch1_req", 64'(got), 64'(sbq1.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    op_valid  = 1'b0;
    op_addr   = '0;
    op_stride = '0;
    op_count  = '0;
    op_l2     = 1'b0;
    req_retry = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_op_retry", 64'(op_retry), 64'h0);
    check("rst_req_valid", 64'(req_valid), 64'h0);
    check("rst_addr0", 64'(ch_addr(0)), 64'h0);
    check("rst_addr1", 64'(ch_addr(1)), 64'h0);
    check("rst_req_l2", 64'(req_l2), 64'h0);
    check("rst_issued", 64'(stat_issued), 64'h0);
    check("rst_stall", 64'(stat_stall), 64'h0);
    check("rst_drop", 64'(stat_drop), 64'h0);
    step(2);
    reset = 1'b1;
    step(2);

    // Basic interleave, two-cycle latency, back-to-back
    push(44'h100, 8'd1, 4'd4, 1'b0);
    check("basic_lat_e0", 64'(req_valid), 64'h0);
    step();
    check("basic_lat_e1", 64'(req_valid), 64'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("basic_valid", 64'(req_valid), (i % 2 == 1) ? 64'h2 : 64'h1);
      check("basic_addr", 64'(ch_addr(i % 2)), 64'h100 + 64'(i));
      step();
    end
    drain("basic");
    check("basic_issued", 64'(stat_issued), 64'd4);

    // Negative stride with wrap below zero, L2 target
    push(44'h1, 8'hFF, 4'd3, 1'b1);
    step(2);
    check("neg_first", 64'({req_valid, req_l2[1], ch_addr(1)}), {17'h0, 2'b10, 1'b1, 44'h1});
    step();
    check("neg_second", 64'({req_valid, req_l2[0], ch_addr(0)}), {17'h0, 2'b01, 1'b1, 44'h0});
    step();
    check("neg_wrap", 64'({req_valid, req_l2[1], ch_addr(1)}), {17'h0, 2'b10, 1'b1, 44'hFFF_FFFF_FFFF});
    drain("neg");
    check("neg_issued", 64'(stat_issued), 64'(n_exp_issued));

    // Backpressure on channel 0 for five cycles
    req_retry = 2'b01;
    push(44'h10, 8'd2, 4'd3, 1'b0);
    step(2);
    check("bp_first", 64'(ch_addr(0)), 64'h10);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", 64'(req_valid), 64'h1);
      check("bp_hold_addr", 64'(ch_addr(0)), 64'h10);
    end
    check("bp_stall", 64'(stat_stall), 64'd5);
    req_retry = 2'b00;
    step();
    check("bp_next", 64'(ch_addr(0)), 64'h12);
    drain("bp");
    check("bp_stall_final", 64'(stat_stall), 64'd5);
    check("bp_issued", 64'(stat_issued), 64'(n_exp_issued));

    // FIFO full while the generator is stalled on channel 0
    req_retry = 2'b01;
    push(44'h40, 8'd2, 4'd2, 1'b0);
    step(3);
    push(44'h50, 8'd1, 4'd1, 1'b0);
    push(44'h52, 8'd1, 4'd1, 1'b0);
    push(44'h54, 8'd1, 4'd1, 1'b0);
    push(44'h56, 8'd1, 4'd1, 1'b0);
    check("full_retry", 64'(op_retry), 64'h1);
    op_valid = 1'b1;
    op_addr  = 44'h58;
    op_count = 4'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_hold_retry", 64'(op_retry), 64'h1);
    end
    req_retry = 2'b00;
    push(44'h58, 8'd1, 4'd1, 1'b0);
    drain("full");
    check("full_issued", 64'(stat_issued), 64'(n_exp_issued));

    // Count-zero descriptor is dropped
    push(44'h30, 8'd1, 4'd0, 1'b0);
    push(44'h20, 8'd1, 4'd1, 1'b0);
    drain("zero");
    check("zero_drop", 64'(stat_drop), 64'd1);
    check("zero_issued", 64'(stat_issued), 64'(n_exp_issued));

    // Asynchronous reset in the middle of a long descriptor
    push(44'h200, 8'd1, 4'd15, 1'b0);
    step(5);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(req_valid), 64'h0);
    check("mid_rst_issued", 64'(stat_issued), 64'h0);
    check("mid_rst_stall", 64'(stat_stall), 64'h0);
    check("mid_rst_drop", 64'(stat_drop), 64'h0);
    check("mid_rst_retry", 64'(op_retry), 64'h0);
    sbq0.delete();
    sbq1.delete();
    n_exp_issued = 0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("post_rst_idle", 64'(req_valid), 64'h0);
    end
    check("post_rst_issued", 64'(stat_issued), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pf_stream_engine.md
# pf_stream_engine

Parametrised stream prefetch engine, the multi-channel successor to the single-shot prefetch engine. Accepts prefetch descriptors (base line address, signed stride, count, target level) from the prefetch generator. Buffers them in a descriptor FIFO and expands each into individual line requests. Requests are interleaved by address across NCH cache-pipe channels with valid/retry flow control, and saturating issue/stall statistics are kept.

## Interface
- NCH, 2: number of request channels; power of two, 1..8
- ADDR_W, 44: line-address width (byte address >> 6)
- STRIDE_W, 8: signed stride width, in lines
- CNT_W, 4: descriptor count width; max 2^CNT_W-1 requests per descriptor
- DEPTH, 4: descriptor FIFO depth; power of two, ≥2
- STAT_W, 16: statistics counter width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  descriptor valid
- op_retry  out  1  descriptor not accepted this cycle
- op_addr  in  ADDR_W  base line address
- op_stride  in  STRIDE_W  signed stride in lines
- op_count  in  CNT_W  number of requests; 0 = discard
- op_l2  in  1  target: 0 = DC, 1 = L2
- req_valid  out  NCH  per-channel request valid
- req_retry  in  NCH  per-channel request retry
- req_addr  out  NCH*ADDR_W  per-channel line address, channel c at [c*ADDR_W +: ADDR_W]
- req_l2  out  NCH  per-channel target level
- stat_issued  out  STAT_W  requests transferred, all channels, saturating
- stat_stall  out  STAT_W  cycles the generator was blocked by a full channel slot, saturating
- stat_drop  out  STAT_W  descriptors discarded (count 0), saturating

## Operation
- Handshake, all interfaces: a transfer occurs when valid && !retry. A sender holding valid with retry high keeps valid and data stable.
- op_retry = FIFO full. It does not look ahead at a same-cycle pop.
- Push when op_valid && !op_retry.
- Descriptor FIFO: DEPTH entries; read/write pointers are log2(DEPTH)+1 bits; full/empty come from pointer MSB compare.
- Generator FSM has two states:
  - IDLE: if FIFO not empty, pop the head. If count==0, increment stat_drop and stay in IDLE. Otherwise load cur_addr=addr, remain=count, stride, l2, and go to ISSUE.
  - ISSUE: target channel ch = cur_addr[log2(NCH)-1:0] (0 when NCH=1).
    - The slot is writable if !req_valid[ch] or (req_valid[ch] && !req_retry[ch]).
    - If writable: write slot (addr=cur_addr, l2), set cur_addr += sign-extended stride (mod 2^ADDR_W, wrap silent), remain -= 1. When remain reaches 0, go to IDLE.
    - If not writable: increment stat_stall and hold all state.
- One idle bubble between consecutive descriptors.
- Channel slot: one register per channel. It is set by a generator write and cleared on transfer unless rewritten the same cycle. Non-targeted channels drain independently.
- stat_issued increments by popcount(req_valid & ~req_retry) per cycle, saturating at 2^STAT_W-1.
- Requests to one channel stay in generation order. No ordering holds across channels.

## Timing
- Reset (reset low, async) clears: FIFO pointers, FSM→IDLE, all slots and stats.
  - Reset values: op_retry=0, req_valid=0, req_addr=0, req_l2=0, stat_*=0.
  - A descriptor in flight is discarded. Outputs change without a clock edge.
- Latency: descriptor accepted at edge E0 → popped at E1 → first slot written at E2 → req_valid high after E2. That is 2 cycles after acceptance.
- Throughput: at most one request per cycle across all channels. A single channel with req_retry held low accepts back-to-back.
- A full FIFO with a same-cycle pop still asserts op_retry. Space appears the following cycle.
- A slot write and a drain on the same channel in the same cycle is legal: the new request replaces the transferring one with no bubble.
- Stats are registered and update the cycle after the event.

## Test plan
- Basic, NCH=2: op addr=0x100, stride=1, count=4, l2=0, retry low.
  - Expect ch0 0x100, ch1 0x101, ch0 0x102, ch1 0x103 on consecutive cycles, first valid 2 cycles after acceptance.
  - Expect stat_issued=4.
- Negative stride and wrap: addr=0x1, stride=-1, count=3.
  - Expect 0x1 (ch1), 0x0 (ch0), 0xFFF_FFFF_FFFF (ch1, ADDR_W=44).
- Backpressure: hold req_retry[0]=1 for 5 cycles during stride=2, count=3 from 0x10 (all ch0).
  - Expect 0x10 held stable for 5 cycles, stat_stall=5, then 0x12 and 0x14 follow.
  - Expect ch1 idle throughout.
- FIFO full: hold generator stalled and push 5 descriptors with DEPTH=4.
  - Expect op_retry=1 after the 4th push while the FIFO is full.
  - Expect the 5th descriptor accepted only after a pop, and all descriptors issued in order.
- Count zero: push count=0, then count=1 addr=0x20.
  - Expect stat_drop=1 and a single request 0x20 on ch0.
- Reset mid-operation: assert reset during ISSUE of a count=15 descriptor.
  - Expect immediate req_valid=0 and stats=0, and no further requests after release.
